mux4_scanner: RTL and testbench
===============================

MUX4_SCANNER -- requirements
Module: mux4_scanner

Interface
REQ-001 Parameter: DWELL, default 4, clock cycles each channel is held on sel before sampling; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  level-sampled request to begin a scan; honoured only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a scan in progress.
REQ-006 cont  input  1  continuous mode; when 1 at end of frame, scanning restarts at channel 0.
REQ-007 mux_out  input  1  selected bit returned by the downstream 4:1 mux (its dout).
REQ-008 sel  output  2  channel select driven to the 4:1 mux.
REQ-009 frame  output  4  last completed frame; bit k is the sample taken with sel=k.
REQ-010 frame_valid  output  1  one-cycle pulse marking a new value on frame.
REQ-011 busy  output  1  high while in SCAN.

Function
REQ-012 The FSM shall have two states, IDLE and SCAN, plus an 8-bit dwell counter and a 4-bit shadow register.
REQ-013 IDLE -> SCAN when start=1 and abort=0 at an edge E0; at E0 sel<=0, dwell counter<=0, busy<=1.
REQ-014 In SCAN, channel k shall be held on sel for exactly DWELL cycles; the counter counts 0..DWELL-1 and wraps.
REQ-015 mux_out shall be sampled into shadow[k] at the edge where the counter equals DWELL-1; sel then increments k->k+1 at that same edge (k<3).
REQ-016 At the channel-3 sample edge (E0+4*DWELL): frame<={mux_out, shadow[2:0]}, frame_valid<=1 for exactly one cycle.
REQ-017 At that edge, cont=1 -> stay in SCAN with sel<=0 and counter<=0 (no gap cycle); cont=0 -> IDLE, busy<=0, sel<=0.
REQ-018 frame shall hold its value until the next completed frame; it shall never show a partial frame.
REQ-019 start in SCAN shall be ignored; start held high in IDLE restarts on the next edge after return to IDLE.
REQ-020 abort=1 in SCAN -> IDLE at the next edge, sel<=0, busy<=0, shadow discarded, frame unchanged, no frame_valid.
REQ-021 abort coincident with the channel-3 sample edge: abort wins; no frame update, no frame_valid.
REQ-022 start and abort both high in IDLE: remain IDLE.
REQ-023 DWELL=1: sel shall advance every cycle; frame_valid repeats every 4 cycles in continuous mode.

Reset
REQ-024 rst=1 shall immediately force IDLE, sel=0, frame=0, frame_valid=0, busy=0, counter=0, shadow=0, independent of clk.
REQ-025 Reset mid-scan shall discard the partial frame; the first edge after rst falls shall act as a normal IDLE edge.

Structure
REQ-026 State encodings (IDLE=0, SCAN=1) and the channel count constant (4) shall live in a shared package mux_pkg.
REQ-027 The dwell counter shall be a sub-module dwell_counter (inputs clk, rst, clear, enable; output terminal-count flag).
REQ-028 mux4_scanner shall not instantiate the mux; the parent connects sel and mux_out to mux4x1.

Verification (DWELL=2 unless stated; mux4x1 model in the loop)
REQ-029 din=4'b1010, start pulse at E0, cont=0 -> sel 0,0,1,1,2,2,3,3; frame=4'b1010 and frame_valid=1 after E0+8; busy=0 after E0+8.
REQ-030 cont=1, din changes 4'b0001 -> 4'b1000 between frames -> consecutive frame_valid pulses 8 cycles apart, frames 0001 then 1000, sel wraps 3->0 with no gap.
REQ-031 abort at E0+5 -> IDLE at E0+6, no frame_valid, frame keeps previous value (e.g. 4'b0110).
REQ-032 abort asserted exactly at E0+8 -> no frame_valid, frame unchanged.
REQ-033 rst asserted asynchronously mid-cycle during channel 2 -> sel, frame, busy, frame_valid read 0 before the next edge; a new start then yields a correct full frame.
REQ-034 DWELL=1, cont=1, din=4'b1111 -> sel 0,1,2,3,0,... every cycle; frame_valid every 4th cycle, frame=4'b1111.

Source files
------------

// File: rtl/mux4_scanner_pkg.sv
// Shared definitions for the 4-channel mux scanner: FSM state encoding,
// channel count and small helpers used by the scanner datapath.
package mux_pkg;

  // Number of channels behind the downstream 4:1 mux.
  localparam int NUM_CH = 4;

  // Width of the channel select bus.
  localparam int SEL_W = 2;

  // Width of the dwell counter; bounds DWELL to 1..255.
  localparam int CNT_W = 8;

  // Highest channel index, the one whose sample closes a frame.
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  // Scanner states: IDLE waits for start, SCAN walks the channels.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Next channel select after a sample; wraps back to channel 0.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
    if (cur == LAST_CH) begin
      return '0;
    end
    return cur + SEL_W'(1);
  endfunction

  // Insert one sampled bit into a frame image at the given channel.
  function automatic logic [NUM_CH-1:0] put_bit(input logic [NUM_CH-1:0] img,
                                                input logic [SEL_W-1:0]  ch,
                                                input logic              b);
    logic [NUM_CH-1:0] res;
    res     = img;
    res[ch] = b;
    return res;
  endfunction

endpackage

// File: rtl/mux4_scanner_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and wraps, flagging the
// terminal count so the scanner knows when a channel has settled long enough.
module dwell_counter
  import mux_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  // Terminal count is decoded from the registered count so it lines up with
  // the edge at which the scanner samples mux_out.
  assign tc = (cnt == LAST_CNT);

  // Count the dwell cycles; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux4_scanner.sv
// 4-channel mux scanner: steps sel through channels 0..3, holding each for
// DWELL cycles, samples the mux output at the end of each dwell and publishes
// the assembled 4-bit frame with a one-cycle frame_valid pulse.
module mux4_scanner
  import mux_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [NUM_CH-1:0] frame,
  output logic             frame_valid,
  output logic             busy
);

  state_t            state;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] captured;
  logic              tc;
  logic              dwell_clear;
  logic              dwell_en;
  logic              sample;

  // The counter sits at zero whenever we are idle or being cancelled, so the
  // first SCAN cycle always starts a fresh dwell.
  assign dwell_clear = (state == IDLE) || abort;
  assign dwell_en    = (state == SCAN);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (dwell_clear),
    .enable (dwell_en),
    .tc     (tc)
  );

  // A sample is taken at the last dwell cycle of a channel unless cancelled.
  assign sample = (state == SCAN) && tc && !abort;

  // Frame image including the bit being sampled right now; used both to
  // update the shadow and to publish a complete frame on the last channel.
  always_comb begin
    captured = put_bit(shadow, sel, mux_out);
  end

  // Scanner FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= SCAN;
            sel    <= '0;
            shadow <= '0;
            busy   <= 1'b1;
          end
        end
        SCAN: begin
          if (abort) begin
            state  <= IDLE;
            sel    <= '0;
            shadow <= '0;
            busy   <= 1'b0;
          end else if (sample) begin
            if (sel == LAST_CH) begin
              frame       <= captured;
              frame_valid <= 1'b1;
              shadow      <= '0;
              sel         <= '0;
              if (!cont) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              shadow <= captured;
              sel    <= next_sel(sel);
            end
          end
        end
        default: begin
          state  <= IDLE;
          sel    <= '0;
          shadow <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_scanner.sv
// Self-checking bench for mux4_scanner: a DWELL=2 and a DWELL=1 instance share
// the same stimulus, each with a 4:1 mux model in the loop, and both are
// compared every cycle against a position-based reference model.
module tb_mux4_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] din = 4'b0000;

  logic [1:0] sel2, sel1;
  logic [3:0] frame2, frame1;
  logic       fv2, fv1, busy2, busy1;
  logic       mux_out2, mux_out1;

  int ncmp = 0;
  int nerr = 0;

  // Downstream 4:1 mux models.
  assign mux_out2 = din[sel2];
  assign mux_out1 = din[sel1];

  mux4_scanner #(.DWELL(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .mux_out(mux_out2), .sel(sel2), .frame(frame2), .frame_valid(fv2), .busy(busy2)
  );

  mux4_scanner #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .mux_out(mux_out1), .sel(sel1), .frame(frame1), .frame_valid(fv1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Reference model: a scan is a position 0..4*DWELL-1; channel = pos/DWELL,
  // and the bit for a channel is taken on the last position of its dwell.
  typedef struct {
    bit       busy;
    int       pos;
    bit [3:0] bits;
    bit [3:0] frame;
    bit       fv;
  } mstate_t;

  mstate_t m2, m1;

  function automatic mstate_t mreset();
    mstate_t s;
    s.busy = 0; s.pos = 0; s.bits = 0; s.frame = 0; s.fv = 0;
    return s;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int dw, bit st, bit ab, bit ct,
                                    bit [3:0] d);
    mstate_t n;
    int ch;
    n = s;
    n.fv = 0;
    ch = s.pos / dw;
    if (!s.busy) begin
      if (st && !ab) begin
        n.busy = 1; n.pos = 0; n.bits = 0;
      end
    end else if (ab) begin
      n.busy = 0; n.pos = 0; n.bits = 0;
    end else begin
      if ((s.pos % dw) == dw - 1) n.bits[ch] = d[ch];
      if (s.pos == 4 * dw - 1) begin
        n.frame = n.bits; n.fv = 1; n.pos = 0; n.bits = 0; n.busy = ct;
      end else begin
        n.pos = s.pos + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] mexp(mstate_t s, int dw);
    logic [1:0] es;
    es = s.busy ? 2'(s.pos / dw) : 2'd0;
    return {es, 4'(s.frame), 1'(s.fv), 1'(s.busy)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare both instances just after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m2 = mreset(); m1 = mreset();
    end else begin
      m2 = mstep(m2, 2, start, abort, cont, din);
      m1 = mstep(m1, 1, start, abort, cont, din);
    end
    #1;
    check("d2_cycle", {sel2, frame2, fv2, busy2}, mexp(m2, 2));
    check("d1_cycle", {sel1, frame1, fv1, busy1}, mexp(m1, 1));
  endtask

  task automatic stop_scan();
    cont = 0; abort = 1; step(); abort = 0; step();
  endtask

  typedef struct {
    logic [3:0] din;
    logic [3:0] exp_frame;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int fcount;
    int fv_at[$];
    logic [3:0] prev;

    m2 = mreset(); m1 = mreset();
    tbl[0] = '{4'b1010, 4'b1010};
    tbl[1] = '{4'b0000, 4'b0000};
    tbl[2] = '{4'b1111, 4'b1111};
    tbl[3] = '{4'b0101, 4'b0101};
    tbl[4] = '{4'b1001, 4'b1001};
    tbl[5] = '{4'b0110, 4'b0110};

    // Reset state.
    repeat (2) step();
    check("rst_sel", sel2, 0);
    check("rst_frame", frame2, 0);
    check("rst_busy", busy2, 0);
    check("rst_fv", fv2, 0);
    rst = 0;
    step();

    // Single-frame vectors, cont=0.
    for (int i = 0; i < 6; i++) begin
      din = tbl[i].din; cont = 0; start = 1;
      step();
      start = 0;
      check("tbl_sel_e0", sel2, 0);
      fcount = 0;
      for (int c = 1; c <= 8; c++) begin
        step();
        if (fv2) fcount++;
        if (c < 8) check("tbl_sel", sel2, c / 2);
      end
      check("tbl_frame", frame2, tbl[i].exp_frame);
      check("tbl_fv_at_e8", fv2, 1);
      check("tbl_fv_count", fcount, 1);
      check("tbl_busy_end", busy2, 0);
      check("tbl_d1_frame", frame1, tbl[i].exp_frame);
      step();
      check("tbl_fv_pulse", fv2, 0);
    end

    // Abort after E0+5 (sampled at E0+6): frame keeps 0110.
    din = 4'b1111; start = 1; step(); start = 0;
    repeat (5) step();
    abort = 1; step(); abort = 0;
    check("abort5_busy", busy2, 0);
    check("abort5_sel", sel2, 0);
    fcount = 0;
    repeat (6) begin step(); if (fv2) fcount++; end
    check("abort5_fv", fcount, 0);
    check("abort5_frame", frame2, 4'b0110);

    // Abort coincident with the channel-3 sample edge E0+8.
    din = 4'b1001; start = 1; step(); start = 0;
    repeat (7) step();
    abort = 1; step(); abort = 0;
    check("abort8_fv", fv2, 0);
    check("abort8_frame", frame2, 4'b0110);
    check("abort8_busy", busy2, 0);
    repeat (2) step();

    // start and abort together in IDLE.
    start = 1; abort = 1; step(); start = 0; abort = 0;
    check("start_abort_idle", busy2, 0);
    step();

    // Continuous mode: 0001 then 1000, pulses 8 apart, no gap at the wrap.
    din = 4'b0001; cont = 1; start = 1; step(); start = 0;
    fv_at.delete();
    for (int c = 1; c <= 16; c++) begin
      step();
      if (fv2) begin
        fv_at.push_back(c);
        if (fv_at.size() == 1) begin
          check("cont_frame1", frame2, 4'b0001);
          check("cont_wrap_sel", sel2, 0);
          check("cont_wrap_busy", busy2, 1);
          din = 4'b1000;
        end else begin
          check("cont_frame2", frame2, 4'b1000);
        end
      end
      if (c == 9) check("cont_sel_nogap", sel2, 0);
      if (c == 10) check("cont_sel_adv", sel2, 1);
    end
    check("cont_fv_count", fv_at.size(), 2);
    if (fv_at.size() == 2) check("cont_fv_spacing", fv_at[1] - fv_at[0], 8);
    stop_scan();

    // Asynchronous reset during channel 2.
    din = 4'b0110; cont = 0; start = 1; step(); start = 0;
    repeat (5) step();
    check("arst_pre_sel", sel2, 2);
    #2 rst = 1;
    #1;
    check("arst_sel", sel2, 0);
    check("arst_frame", frame2, 0);
    check("arst_busy", busy2, 0);
    check("arst_fv", fv2, 0);
    m2 = mreset(); m1 = mreset();
    step();
    rst = 0;
    din = 4'b1101; start = 1; step(); start = 0;
    repeat (8) step();
    check("arst_new_frame", frame2, 4'b1101);
    check("arst_new_fv", fv2, 1);
    step();

    // DWELL=1 continuous with 1111.
    din = 4'b1111; cont = 1; start = 1; step(); start = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      check("d1_sel_seq", sel1, i % 4);
      check("d1_fv_seq", fv1, (i > 0 && i % 4 == 0) ? 1 : 0);
    end
    check("d1_frame", frame1, 4'b1111);
    stop_scan();

    // Randomized traffic against the model.
    prev = 0;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      cont  = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) din = 4'($urandom);
      step();
      if (fv2) prev = frame2;
    end
    start = 0; abort = 0; cont = 0;
    repeat (12) step();
    check("rand_idle", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
